// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the 1R1W SRAM model with zero-init sweep.
//   sram_state_e     : sweep controller states (INIT, READY)
//   SRAM_MAX_WIDTH   : widest word the lane-merge helper handles
//   sram_width_ok    : elaboration-time legality check for DATA_WIDTH/MASK_GRAN
//   sram_lane_merge  : combine old and new words under a bit-expanded lane mask
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int unsigned SRAM_MAX_WIDTH = 1024;

  // Words must split into whole mask lanes and fit the merge helper.
  function automatic bit sram_width_ok(input int unsigned data_width,
                                       input int unsigned mask_gran);
    return (mask_gran != 0) &&
           ((data_width % mask_gran) == 0) &&
           (data_width <= SRAM_MAX_WIDTH);
  endfunction

  // bit_mask is the lane mask already replicated across each lane's bits:
  // set bits take new_word, clear bits keep old_word.
  function automatic logic [SRAM_MAX_WIDTH-1:0] sram_lane_merge(
      input logic [SRAM_MAX_WIDTH-1:0] old_word,
      input logic [SRAM_MAX_WIDTH-1:0] new_word,
      input logic [SRAM_MAX_WIDTH-1:0] bit_mask);
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// -----------------------------------------------------------------------------
// sram_init_seq
// Post-reset zero-initialisation sequencer. After reset releases it walks
// init_addr_o from 0 to DEPTH-1, one word per cycle, then parks in READY
// until the next reset.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   init_write_o  high on every cycle the array must write zero at init_addr_o
//   init_addr_o   word being cleared this cycle
//   init_done_o   registered; high from the cycle after the last clear
// -----------------------------------------------------------------------------
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  init_write_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o,
  output logic                  init_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  sram_state_e           state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (ptr_q == LAST_ADDR) begin
            state_q <= READY;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + ADDR_ONE;
          end
        end
        default: begin
          // READY is terminal; only reset leaves it.
          state_q <= READY;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  // The reset cycle itself must not touch the array, even though the state
  // register may already read INIT.
  assign init_write_o = (state_q == INIT) && rst_ni;
  assign init_addr_o  = ptr_q;
  assign init_done_o  = done_q;

endmodule

// File: rtl/sram_1r1w_init_ext.sv
// -----------------------------------------------------------------------------
// sram_1r1w_init_ext
// One-read / one-write SRAM model with per-lane write mask, hardware zero
// sweep after reset, write-first same-address forwarding and a read-valid
// strobe. Backing array for cache tag/data stores and TLB wrappers.
//
// Optional build macro SRAM_OUT_REG_EN: adds one output register stage,
// making read latency 2 instead of 1. Array contents and sweep timing are
// unchanged; forwarding is still resolved at the request edge.
//
// Ports:
//   clock      sole clock, rising edge
//   reset_n    synchronous active-low reset; restarts the zero sweep
//   init_done  high once every word has been cleared
//   R0_en      read request (ignored until init_done)
//   R0_addr    read address; addresses >= DEPTH read back all-zero
//   R0_valid   one-cycle strobe marking fresh R0_data
//   R0_data    registered read data, holds between reads
//   W0_en      write request (ignored until init_done)
//   W0_addr    write address; addresses >= DEPTH are dropped
//   W0_mask    lane i enables bits [i*MASK_GRAN +: MASK_GRAN]
//   W0_data    write data
// -----------------------------------------------------------------------------
module sram_1r1w_init_ext
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 86,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned MASK_GRAN  = 43,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NUM_LANES  = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  init_done,
  input  logic                  R0_en,
  input  logic [ADDR_WIDTH-1:0] R0_addr,
  output logic                  R0_valid,
  output logic [DATA_WIDTH-1:0] R0_data,
  input  logic                  W0_en,
  input  logic [ADDR_WIDTH-1:0] W0_addr,
  input  logic [NUM_LANES-1:0]  W0_mask,
  input  logic [DATA_WIDTH-1:0] W0_data
);

  localparam bit WIDTH_OK = sram_width_ok(DATA_WIDTH, MASK_GRAN);

  if (!WIDTH_OK) begin : g_bad_width
    $error("sram_1r1w_init_ext: DATA_WIDTH must be a multiple of MASK_GRAN");
  end

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_word(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [DATA_WIDTH-1:0] bit_mask);
    logic [SRAM_MAX_WIDTH-1:0] wide;
    wide = sram_lane_merge(SRAM_MAX_WIDTH'(old_word),
                           SRAM_MAX_WIDTH'(new_word),
                           SRAM_MAX_WIDTH'(bit_mask));
    return wide[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  init_write;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram_init_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .init_write_o (init_write),
    .init_addr_o  (init_addr),
    .init_done_o  (init_done)
  );

  logic [DATA_WIDTH-1:0] wr_bitmask;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wr_bitmask[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[l]}};
  end

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  collide;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_in_range = ({1'b0, W0_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_X);

  // init_done can still be high in the first reset cycle after READY, so
  // the write path is gated by reset_n as well.
  assign wr_fire = reset_n && init_done && W0_en && wr_in_range;
  assign rd_fire = init_done && R0_en;
  assign collide = wr_fire && (W0_addr == R0_addr);

  assign wr_old    = ram[W0_addr];
  assign wr_merged = merge_word(wr_old, W0_data, wr_bitmask);
  assign rd_raw    = ram[R0_addr];

  // Write-first per lane on a same-address collision: enabled lanes see the
  // incoming data, the rest see the pre-write array contents.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = collide ? merge_word(rd_raw, W0_data, wr_bitmask) : rd_raw;
    end
  end

  // The sweep and the write port never overlap: writes need init_done.
  always_ff @(posedge clock) begin
    if (init_write) begin
      ram[init_addr] <= '0;
    end else if (wr_fire) begin
      ram[W0_addr] <= wr_merged;
    end
  end

  // ---- stage p1: read register ----
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rd_fire;
      if (rd_fire) begin
        data_p1 <= rd_word;
      end
    end
  end

`ifdef SRAM_OUT_REG_EN
  // ---- stage p2: optional output register ----
  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] data_p2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= data_p1;
      end
    end
  end

  assign R0_valid = vld_p2;
  assign R0_data  = data_p2;
`else
  assign R0_valid = vld_p1;
  assign R0_data  = data_p1;
`endif

endmodule

// File: tb/tb_sram_1r1w_init_ext.sv
module tb_sram_1r1w_init_ext;

  localparam int DW = 86;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  // DUT A: DEPTH 256
  logic          a_init_done, a_R0_en, a_R0_valid, a_W0_en;
  logic [7:0]    a_R0_addr, a_W0_addr;
  logic [1:0]    a_W0_mask;
  logic [DW-1:0] a_R0_data, a_W0_data;
  // DUT B: DEPTH 200
  logic          b_init_done, b_R0_en, b_R0_valid, b_W0_en;
  logic [7:0]    b_R0_addr, b_W0_addr;
  logic [1:0]    b_W0_mask;
  logic [DW-1:0] b_R0_data, b_W0_data;

  sram_1r1w_init_ext #(.DATA_WIDTH(86), .DEPTH(256), .MASK_GRAN(43)) dut_a (
    .clock(clk), .reset_n(reset_n), .init_done(a_init_done),
    .R0_en(a_R0_en), .R0_addr(a_R0_addr), .R0_valid(a_R0_valid), .R0_data(a_R0_data),
    .W0_en(a_W0_en), .W0_addr(a_W0_addr), .W0_mask(a_W0_mask), .W0_data(a_W0_data));

  sram_1r1w_init_ext #(.DATA_WIDTH(86), .DEPTH(200), .MASK_GRAN(43)) dut_b (
    .clock(clk), .reset_n(reset_n), .init_done(b_init_done),
    .R0_en(b_R0_en), .R0_addr(b_R0_addr), .R0_valid(b_R0_valid), .R0_data(b_R0_data),
    .W0_en(b_W0_en), .W0_addr(b_W0_addr), .W0_mask(b_W0_mask), .W0_data(b_W0_data));

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [200];
  int            cyc  = 0;
  int            nchk = 0;
  int            nerr = 0;

  function automatic logic [DW-1:0] lanes(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [1:0] m);
    logic [DW-1:0] r;
    r[85:43] = m[1] ? n[85:43] : o[85:43];
    r[42:0]  = m[0] ? n[42:0]  : o[42:0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
    for (int i = 0; i < 200; i++) mem_b[i] = '0;
    qa.delete();
    qb.delete();
  endtask

  // Drive one cycle of stimulus on DUT A (sel=0) or B (sel=1); update the
  // reference memory and queue the expected read result.
  task automatic drive(input bit sel, input bit ren, input int ra, input bit wen, input int wa,
                       input logic [1:0] m, input logic [DW-1:0] wd);
    exp_t e;
    int   dep;
    dep   = sel ? 200 : 256;
    e.due = cyc + LAT;
    e.d   = '0;
    if (ren && ra < dep) begin
      if (sel) e.d = (wen && wa == ra) ? lanes(mem_b[ra], wd, m) : mem_b[ra];
      else     e.d = (wen && wa == ra) ? lanes(mem_a[ra], wd, m) : mem_a[ra];
    end
    if (!sel) begin
      a_R0_en = ren; a_R0_addr = 8'(ra); a_W0_en = wen; a_W0_addr = 8'(wa);
      a_W0_mask = m; a_W0_data = wd;
      if (ren) qa.push_back(e);
      if (wen && wa < dep) mem_a[wa] = lanes(mem_a[wa], wd, m);
    end else begin
      b_R0_en = ren; b_R0_addr = 8'(ra); b_W0_en = wen; b_W0_addr = 8'(wa);
      b_W0_mask = m; b_W0_data = wd;
      if (ren) qb.push_back(e);
      if (wen && wa < dep) mem_b[wa] = lanes(mem_b[wa], wd, m);
    end
  endtask

  task automatic test_reset();
    int cnt;
    int b_done_at;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, '0);
    drive(1, 0, 0, 0, 0, 2'b00, '0);
    step();
    step();
    nchk++; if (a_init_done !== 1'b0) begin nerr++; $display("FAIL reset_init_done got=%b want=0", a_init_done); end
    nchk++; if (a_R0_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b want=0", a_R0_valid); end
    nchk++; if (a_R0_data !== '0) begin nerr++; $display("FAIL reset_data got=%h want=0", a_R0_data); end
    nchk++; if (b_init_done !== 1'b0) begin nerr++; $display("FAIL reset_b_init_done got=%b want=0", b_init_done); end
    reset_n   = 1'b1;
    cnt       = 0;
    b_done_at = -1;
    while (a_init_done !== 1'b1 && cnt < 400) begin
      // Late in A's sweep, hammer an already-cleared word; it must be ignored.
      a_R0_en   = (cnt >= 200 && cnt < 250);
      a_W0_en   = (cnt >= 200 && cnt < 250);
      a_R0_addr = 8'd3; a_W0_addr = 8'd3; a_W0_mask = 2'b11; a_W0_data = '1;
      step();
      cnt++;
      if (b_init_done === 1'b1 && b_done_at < 0) b_done_at = cnt;
      if (a_init_done !== 1'b1) begin
        nchk++;
        if (a_R0_valid !== 1'b0) begin nerr++; $display("FAIL init_no_valid cnt=%0d got=%b want=0", cnt, a_R0_valid); end
      end
    end
    drive(0, 0, 0, 0, 0, 2'b00, '0);
    nchk++; if (cnt != 256) begin nerr++; $display("FAIL sweep_len_a got=%0d want=256", cnt); end
    nchk++; if (b_done_at != 200) begin nerr++; $display("FAIL sweep_len_b got=%0d want=200", b_done_at); end
    clear_model();
  endtask

  task automatic test_read_zero();
    int addrs[4] = '{0, 128, 255, 3};
    for (int i = 0; i < 4 + LAT + 1; i++) begin
      if (i < 4) drive(0, 1, addrs[i], 0, 0, 2'b00, '0);
      else       drive(0, 0, 0, 0, 0, 2'b00, '0);
      step();
      nchk++;
      if (qa.size() != 0 && qa[0].due == cyc) begin
        if (a_R0_valid !== 1'b1 || a_R0_data !== qa[0].d) begin
          nerr++; $display("FAIL read_zero cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, a_R0_valid, a_R0_data, qa[0].d);
        end
        void'(qa.pop_front());
      end else if (a_R0_valid !== 1'b0) begin
        nerr++; $display("FAIL read_zero_idle cyc=%0d got valid=%b want 0", cyc, a_R0_valid);
      end
    end
    nchk++; if (qa.size() != 0) begin nerr++; $display("FAIL read_zero_drain got=%0d pending want=0", qa.size()); end
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] hold;
    hold = {{43{1'b1}}, {43{1'b0}}};
    for (int i = 0; i < 3 + LAT + 2; i++) begin
      case (i)
        0:       drive(0, 0, 0, 1, 5, 2'b11, '1);
        1:       drive(0, 0, 0, 1, 5, 2'b01, '0);
        2:       drive(0, 1, 5, 0, 0, 2'b00, '0);
        default: drive(0, 0, 0, 0, 0, 2'b00, '0);
      endcase
      step();
      nchk++;
      if (qa.size() != 0 && qa[0].due == cyc) begin
        if (a_R0_valid !== 1'b1 || a_R0_data !== qa[0].d) begin
          nerr++; $display("FAIL masked_write cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, a_R0_valid, a_R0_data, qa[0].d);
        end
        void'(qa.pop_front());
      end else if (a_R0_valid !== 1'b0) begin
        nerr++; $display("FAIL masked_write_idle cyc=%0d got valid=%b want 0", cyc, a_R0_valid);
      end
    end
    nchk++;
    if (a_R0_data !== hold) begin nerr++; $display("FAIL masked_hold got=%h want=%h", a_R0_data, hold); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] va, vb, vc, want;
    va = DW'({$urandom(), $urandom(), $urandom()});
    vb = ~va;
    vc = DW'({$urandom(), $urandom(), $urandom()});
    want = {vb[85:43], va[42:0]};
    for (int i = 0; i < 4 + LAT + 1; i++) begin
      case (i)
        0:       drive(0, 0, 0, 1, 9, 2'b11, va);
        1:       drive(0, 1, 9, 1, 9, 2'b10, vb);
        2:       drive(0, 1, 9, 1, 9, 2'b00, vc);
        3:       drive(0, 1, 9, 0, 0, 2'b00, '0);
        default: drive(0, 0, 0, 0, 0, 2'b00, '0);
      endcase
      step();
      nchk++;
      if (qa.size() != 0 && qa[0].due == cyc) begin
        if (a_R0_valid !== 1'b1 || a_R0_data !== qa[0].d || a_R0_data !== want) begin
          nerr++; $display("FAIL collision cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, a_R0_valid, a_R0_data, want);
        end
        void'(qa.pop_front());
      end else if (a_R0_valid !== 1'b0) begin
        nerr++; $display("FAIL collision_idle cyc=%0d got valid=%b want 0", cyc, a_R0_valid);
      end
    end
  endtask

  task automatic test_out_of_range();
    int addrs[5] = '{210, 10, 82, 199, 255};
    for (int i = 0; i < 6 + LAT + 1; i++) begin
      if (i == 0)     drive(1, 0, 0, 1, 210, 2'b11, '1);
      else if (i < 6) drive(1, 1, addrs[i-1], 0, 0, 2'b00, '0);
      else            drive(1, 0, 0, 0, 0, 2'b00, '0);
      step();
      nchk++;
      if (qb.size() != 0 && qb[0].due == cyc) begin
        if (b_R0_valid !== 1'b1 || b_R0_data !== qb[0].d) begin
          nerr++; $display("FAIL out_of_range cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, b_R0_valid, b_R0_data, qb[0].d);
        end
        void'(qb.pop_front());
      end else if (b_R0_valid !== 1'b0) begin
        nerr++; $display("FAIL out_of_range_idle cyc=%0d got valid=%b want 0", cyc, b_R0_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    for (int i = 0; i < 16 + LAT + 1; i++) begin
      v = {11'h5A5, 32'(i * 32'h01010101), 11'h3C3, 32'(~i)};
      if (i < 8)       drive(0, 0, 0, 1, i, 2'b11, v);
      else if (i < 16) drive(0, 1, i - 8, 0, 0, 2'b00, '0);
      else             drive(0, 0, 0, 0, 0, 2'b00, '0);
      step();
      nchk++;
      if (qa.size() != 0 && qa[0].due == cyc) begin
        if (a_R0_valid !== 1'b1 || a_R0_data !== qa[0].d) begin
          nerr++; $display("FAIL back_to_back cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, a_R0_valid, a_R0_data, qa[0].d);
        end
        void'(qa.pop_front());
      end else if (a_R0_valid !== 1'b0) begin
        nerr++; $display("FAIL back_to_back_idle cyc=%0d got valid=%b want 0", cyc, a_R0_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    drive(0, 0, 0, 1, 20, 2'b11, {43'h1234567, 43'h7654321});
    step();
    // Read in flight when reset lands: must be discarded.
    drive(0, 1, 20, 0, 0, 2'b00, '0);
    reset_n = 1'b0;
    step();
    drive(0, 0, 0, 0, 0, 2'b00, '0);
    nchk++; if (a_R0_valid !== 1'b0) begin nerr++; $display("FAIL reset_mid_valid got=%b want=0", a_R0_valid); end
    nchk++; if (a_init_done !== 1'b0) begin nerr++; $display("FAIL reset_mid_done got=%b want=0", a_init_done); end
    step();
    nchk++; if (a_R0_valid !== 1'b0 || a_R0_data !== '0) begin nerr++; $display("FAIL reset_mid_out got valid=%b data=%h want 0/0", a_R0_valid, a_R0_data); end
    clear_model();
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    nchk++; if (a_init_done !== 1'b0) begin nerr++; $display("FAIL sweep100_done got=%b want=0", a_init_done); end
    reset_n = 1'b0;
    step();
    nchk++; if (a_init_done !== 1'b0) begin nerr++; $display("FAIL resweep_done got=%b want=0", a_init_done); end
    reset_n = 1'b1;
    cnt = 0;
    while (a_init_done !== 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    nchk++; if (cnt != 256) begin nerr++; $display("FAIL resweep_len got=%0d want=256", cnt); end
    for (int i = 0; i < 1 + LAT + 1; i++) begin
      if (i == 0) drive(0, 1, 20, 0, 0, 2'b00, '0);
      else        drive(0, 0, 0, 0, 0, 2'b00, '0);
      step();
      nchk++;
      if (qa.size() != 0 && qa[0].due == cyc) begin
        if (a_R0_valid !== 1'b1 || a_R0_data !== qa[0].d) begin
          nerr++; $display("FAIL reset_mid_read cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, a_R0_valid, a_R0_data, qa[0].d);
        end
        void'(qa.pop_front());
      end else if (a_R0_valid !== 1'b0) begin
        nerr++; $display("FAIL reset_mid_idle cyc=%0d got valid=%b want 0", cyc, a_R0_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_zero();
    test_masked_write();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
